imem_boot_loader: RTL and testbench

Boot-time controller for the single-cycle core's instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, writes them sequentially into instruction memory, and holds the core stalled until the image is complete. After a successful load it hands the instruction-memory read address over to the core's PC.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_word_packer.sv | 29 ++
 rtl/imem_boot_loader.sv | 117 +++++++++++
 tb/tb_imem_boot_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and stream-format constants for the instruction-memory boot loader.
// Optional feature macro used by the loader: IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      DATA,
      WRITE,
      CHK,
      DONE,
      ERR
   } state_e;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles four stream bytes, least-significant first, into one 32-bit word.
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        byte_stb,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_full
);

   logic [1:0] cnt;

   // Right shift puts the first byte in bits [7:0] once all four have arrived.
   assign word_full = byte_stb && (cnt == 2'(WORD_BYTES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         cnt  <= '0;
         word <= '0;
      end else if (byte_stb) begin
         cnt  <= cnt + 2'd1;
         word <= {byte_in, word[31:8]};
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed image into instruction memory and holds the core until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_boot_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   input  logic [ADDR_W-1:0] cpu_pc,
   output logic [ADDR_W-1:0] imem_raddr,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;

   state_e           state, state_nxt;
   logic [IDX_W-1:0] word_idx;
   logic [IDX_W-1:0] idx_inc;
   logic [15:0]      n_words;
   logic [15:0]      n_hdr;
   logic             xfer;
   logic             start_load;
   logic             word_full;
   logic [31:0]      packed_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]       csum;
`endif

   assign xfer       = byte_valid && byte_ready;
   assign start_load = start && (state == IDLE || state == DONE || state == ERR);
   assign idx_inc    = word_idx + 1'b1;
   assign n_hdr      = {byte_data, n_words[7:0]};

   imem_word_packer u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (start_load),
      .byte_stb  (xfer && state == DATA),
      .byte_in   (byte_data),
      .word      (packed_word),
      .word_full (word_full)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERR: if (start) state_nxt = HDR0;
         HDR0:  if (xfer) state_nxt = HDR1;
         HDR1:  if (xfer) state_nxt = (n_hdr == 16'd0 || n_hdr > 16'(DEPTH_WORDS)) ? ERR : DATA;
         DATA:  if (word_full) state_nxt = WRITE;
         WRITE: begin
            if (16'(idx_inc) < n_words) state_nxt = DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            else                        state_nxt = CHK;
`else
            else                        state_nxt = DONE;
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHK:   if (xfer) state_nxt = (byte_data == csum) ? DONE : ERR;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they change on the same edge as state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         word_idx   <= '0;
         n_words    <= '0;
         byte_ready <= 1'b0;
         imem_we    <= 1'b0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         state      <= state_nxt;
         byte_ready <= (state_nxt inside {HDR0, HDR1, DATA, CHK});
         imem_we    <= (state_nxt == WRITE);
         cpu_hold   <= (state_nxt != DONE);
         done       <= (state_nxt == DONE);
         error      <= (state_nxt == ERR);
         if (start_load) begin
            word_idx <= '0;
            n_words  <= '0;
         end else begin
            if (xfer && state == HDR0) n_words[7:0]  <= byte_data;
            if (xfer && state == HDR1) n_words[15:8] <= byte_data;
            if (state == WRITE)        word_idx      <= idx_inc;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (start_load) csum <= '0;
         else if (xfer)  csum <= csum ^ byte_data;
`endif
      end
   end

   assign imem_waddr = ADDR_W'({word_idx, 2'b00});
   assign imem_wdata = packed_word;
   assign imem_raddr = (state == DONE) ? cpu_pc : imem_waddr;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader; also covers the IMEM_LOADER_CHECKSUM_EN build.
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        rst_n, start, byte_valid, byte_ready;
   logic [7:0]  byte_data;
   logic [31:0] cpu_pc, imem_raddr, imem_waddr, imem_wdata;
   logic        imem_we, cpu_hold, done, error;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          cyc0 = 0;
   int          rdy_in_wr = 0;
   logic [7:0]  x;
   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   imem_boot_loader #(.DEPTH_WORDS(64), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready), .cpu_pc(cpu_pc),
      .imem_raddr(imem_raddr), .imem_we(imem_we), .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (imem_we) begin
         wa_q.push_back(imem_waddr);
         wd_q.push_back(imem_wdata);
         if (byte_ready) rdy_in_wr++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc0 = cyc;
      x = 8'h00;
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      byte_data  = b;
      byte_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (byte_ready) break;
         n++;
         if (n > 50) begin
            chk("send_timeout", 32'(n), 32'd0);
            break;
         end
      end
      @(posedge clk); #1;
      byte_valid = 1'b0;
      x = x ^ b;
   endtask

   task automatic send_word(input logic [31:0] w, input bit slow);
      for (int i = 0; i < 4; i++) begin
         send(w[8*i +: 8]);
         if (slow) begin @(posedge clk); #1; end
      end
   endtask

   task automatic finish_load();
      logic [7:0] c;
      c = x;
      if (CK != 0) send(c);
   endtask

   task automatic wait_end(output int cyc_at);
      bit ok;
      ok = 0;
      cyc_at = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done || error) begin ok = 1; cyc_at = cyc; break; end
      end
      if (!ok) chk("wait_end_timeout", 32'd0, 32'd1);
   endtask

   task automatic chk_writes(input string tag, input int n,
                             input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
      logic [31:0] exp_w[3];
      exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2;
      chk({tag, "_nwr"}, 32'(wa_q.size()), 32'(n));
      for (int i = 0; i < n && i < wa_q.size(); i++) begin
         chk($sformatf("%s_a%0d", tag, i), wa_q[i], 32'(4 * i));
         chk($sformatf("%s_d%0d", tag, i), wd_q[i], exp_w[i]);
      end
   endtask

   initial begin
      int t_end;
      rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; cpu_pc = 32'h0; x = 8'h00;

      // reset values
      @(posedge clk); @(negedge clk);
      chk("rst_hold", 32'(cpu_hold), 32'd1);
      chk("rst_ready", 32'(byte_ready), 32'd0);
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_waddr", imem_waddr, 32'h0);
      chk("rst_wdata", imem_wdata, 32'h0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;

      // N=3 back-to-back
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send(8'h03); send(8'h00);
      send_word(32'h00000013, 0); send_word(32'h00100093, 0); send_word(32'hFE000EE3, 0);
      finish_load();
      wait_end(t_end);
      chk("b2b_cycles", 32'(t_end - cyc0), 32'(17 + CK));
      chk("b2b_done", 32'(done), 32'd1);
      chk("b2b_hold", 32'(cpu_hold), 32'd0);
      chk("b2b_error", 32'(error), 32'd0);
      chk_writes("b2b", 3, 32'h00000013, 32'h00100093, 32'hFE000EE3);
      cpu_pc = 32'h8; #1;
      chk("b2b_raddr", imem_raddr, 32'h8);
      @(posedge clk); #1;

      // N=0 header
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send(8'h00); send(8'h00);
      wait_end(t_end);
      chk("n0_error", 32'(error), 32'd1);
      chk("n0_hold", 32'(cpu_hold), 32'd1);
      chk("n0_done", 32'(done), 32'd0);
      chk("n0_nwr", 32'(wa_q.size()), 32'd0);
      @(posedge clk); #1;

      // N=65 exceeds depth
      pulse_start();
      send(8'h41); send(8'h00);
      wait_end(t_end);
      chk("n65_error", 32'(error), 32'd1);
      chk("n65_hold", 32'(cpu_hold), 32'd1);
      chk("n65_nwr", 32'(wa_q.size()), 32'd0);
      @(posedge clk); #1;

      // N=2 with byte_valid toggling
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send(8'h02); @(posedge clk); #1; send(8'h00); @(posedge clk); #1;
      send_word(32'h00000013, 1); send_word(32'h00100093, 1);
      finish_load();
      wait_end(t_end);
      chk("slow_done", 32'(done), 32'd1);
      chk_writes("slow", 2, 32'h00000013, 32'h00100093, 32'h0);
      chk("rdy_in_write", 32'(rdy_in_wr), 32'd0);
      @(posedge clk); #1;

      // reset mid-load after 6 data bytes
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send(8'h02); send(8'h00);
      send_word(32'hA5A5_1234, 0); send(8'h77); send(8'h88);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mrst_hold", 32'(cpu_hold), 32'd1);
      chk("mrst_ready", 32'(byte_ready), 32'd0);
      chk("mrst_we", 32'(imem_we), 32'd0);
      chk("mrst_waddr", imem_waddr, 32'h0);
      chk("mrst_wdata", imem_wdata, 32'h0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_error", 32'(error), 32'd0);
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send(8'h01); send(8'h00);
      send_word(32'hCAFEF00D, 0);
      finish_load();
      wait_end(t_end);
      chk("mrst_reload_done", 32'(done), 32'd1);
      chk_writes("mrst_reload", 1, 32'hCAFEF00D, 32'h0, 32'h0);
      @(posedge clk); #1;

      // start during DATA ignored, start in DONE restarts
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send(8'h02); send(8'h00);
      send(8'h11); send(8'h22);
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      send(8'h33); send(8'h44);
      send_word(32'h0BADC0DE, 0);
      finish_load();
      wait_end(t_end);
      chk("ign_done", 32'(done), 32'd1);
      chk_writes("ign", 2, 32'h44332211, 32'h0BADC0DE, 32'h0);
      @(posedge clk); #1;
      pulse_start();
      chk("restart_done", 32'(done), 32'd0);
      chk("restart_hold", 32'(cpu_hold), 32'd1);
      chk("restart_ready", 32'(byte_ready), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // checksum good (loader already in HDR0)
      send(8'h01); send(8'h00); send_word(32'h11223344, 0);
      send(8'h45);
      wait_end(t_end);
      chk("ck_good_done", 32'(done), 32'd1);
      chk("ck_good_err", 32'(error), 32'd0);
      @(posedge clk); #1;
      pulse_start();
      send(8'h01); send(8'h00); send_word(32'h11223344, 0);
      send(8'h00);
      wait_end(t_end);
      chk("ck_bad_err", 32'(error), 32'd1);
      chk("ck_bad_done", 32'(done), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
